// File: rtl/sram_ctl_pkg.sv
// Shared types and sizing for the single-port SRAM front-end controller.
package sram_ctl_pkg;

    localparam int unsigned DEPTH      = 512;
    localparam int unsigned ADDR_W     = $clog2(DEPTH);
    localparam int unsigned DATA_W     = 40;
    localparam int unsigned MASK_W     = 10;
    localparam int unsigned SEG_W      = DATA_W / MASK_W;
    localparam int unsigned STARVE_LIM = 4;
    localparam int unsigned STARVE_W   = $clog2(STARVE_LIM + 1);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    // One command presented on the macro's RW port in a given cycle.
    typedef struct packed {
        logic              en;
        logic              wmode;
        logic [ADDR_W-1:0] addr;
        logic [MASK_W-1:0] wmask;
        logic [DATA_W-1:0] wdata;
    } sram_cmd_t;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester channels (write, read, response) plus the RW0 macro pins.
interface sram_port_arbiter_if;
    import sram_ctl_pkg::*;

    logic              w_valid;
    logic              w_ready;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic [MASK_W-1:0] w_mask;

    logic              r_valid;
    logic              r_ready;
    logic [ADDR_W-1:0] r_addr;

    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;

    logic              sram_en;
    logic              sram_wmode;
    logic [ADDR_W-1:0] sram_addr;
    logic [MASK_W-1:0] sram_wmask;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    // Arbiter side
    modport slave (
        input  w_valid, w_addr, w_data, w_mask,
        output w_ready,
        input  r_valid, r_addr,
        output r_ready,
        output resp_valid, resp_data,
        input  resp_ready,
        output sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata,
        input  sram_rdata
    );

    // Requester / macro side
    modport master (
        output w_valid, w_addr, w_data, w_mask,
        input  w_ready,
        output r_valid, r_addr,
        input  r_ready,
        input  resp_valid, resp_data,
        output resp_ready,
        input  sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata,
        output sram_rdata
    );

endinterface

// File: rtl/sram_rsp_buf.sv
// Read response stage: pass-through on the first cycle, then a hold register
// keeps the data stable under backpressure even if the array is rewritten.
module sram_rsp_buf
    import sram_ctl_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              rd_issue_i,
    input  logic              resp_ready_i,
    input  logic [DATA_W-1:0] sram_rdata_i,
    output logic              resp_valid_o,
    output logic [DATA_W-1:0] resp_data_c,
    output logic              can_accept_c
);

    logic              pend_q,  pend_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] hold_q,  hold_d;

    always_comb begin
        pend_d  = rd_issue_i;
        valid_d = valid_q;
        hold_d  = hold_q;
        if (pend_q) begin
            hold_d = sram_rdata_i;
        end
        // A new issue in the handshake cycle keeps the response valid.
        if (rd_issue_i) begin
            valid_d = 1'b1;
        end else if (valid_q && resp_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend_q  <= 1'b0;
            valid_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            pend_q  <= pend_d;
            valid_q <= valid_d;
            hold_q  <= hold_d;
        end
    end

    assign resp_valid_o = valid_q;
    assign resp_data_c  = pend_q ? sram_rdata_i : hold_q;
    assign can_accept_c = !valid_q || resp_ready_i;

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one masked single-port SRAM between a writer and a reader, zero-fills
// the array after reset, and bounds write starvation under read pressure.
module sram_port_arbiter
    import sram_ctl_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    output logic               init_done,
    sram_port_arbiter_if.slave bus
);

    state_e              state_q,     state_d;
    logic [ADDR_W-1:0]   ctr_q,       ctr_d;
    logic                init_done_q, init_done_d;
    logic [STARVE_W-1:0] starve_q,    starve_d;

    logic      rd_ok;
    logic      w_grant;
    logic      r_grant;
    logic      can_accept;
    sram_cmd_t cmd;

    always_comb begin
        state_d     = state_q;
        ctr_d       = ctr_q;
        init_done_d = init_done_q;
        starve_d    = starve_q;
        rd_ok       = 1'b0;
        w_grant     = 1'b0;
        r_grant     = 1'b0;
        cmd         = '0;

        case (state_q)
            INIT: begin
                cmd.en    = 1'b1;
                cmd.wmode = 1'b1;
                cmd.addr  = ctr_q;
                cmd.wmask = '1;
                ctr_d     = ctr_q + ADDR_W'(1);
                if (ctr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d     = RUN;
                    init_done_d = 1'b1;
                end
            end
            RUN: begin
                rd_ok   = bus.r_valid && can_accept;
                // A write that has waited STARVE_LIM cycles overrides the read.
                w_grant = bus.w_valid &&
                          (!rd_ok || (starve_q == STARVE_W'(STARVE_LIM)));
                r_grant = rd_ok && !w_grant;

                if (w_grant) begin
                    cmd.en    = 1'b1;
                    cmd.wmode = 1'b1;
                    cmd.addr  = bus.w_addr;
                    cmd.wmask = bus.w_mask;
                    cmd.wdata = bus.w_data;
                end else if (r_grant) begin
                    cmd.en    = 1'b1;
                    cmd.addr  = bus.r_addr;
                end

                if (!bus.w_valid || w_grant) begin
                    starve_d = '0;
                end else if (starve_q != STARVE_W'(STARVE_LIM)) begin
                    starve_d = starve_q + STARVE_W'(1);
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= INIT;
            ctr_q       <= '0;
            init_done_q <= 1'b0;
            starve_q    <= '0;
        end else begin
            state_q     <= state_d;
            ctr_q       <= ctr_d;
            init_done_q <= init_done_d;
            starve_q    <= starve_d;
        end
    end

    sram_rsp_buf u_rsp_buf (
        .clock        (clock),
        .reset_n      (reset_n),
        .rd_issue_i   (r_grant),
        .resp_ready_i (bus.resp_ready),
        .sram_rdata_i (bus.sram_rdata),
        .resp_valid_o (bus.resp_valid),
        .resp_data_c  (bus.resp_data),
        .can_accept_c (can_accept)
    );

    assign init_done      = init_done_q;
    assign bus.w_ready    = w_grant;
    assign bus.r_ready    = r_grant;
    assign bus.sram_en    = cmd.en;
    assign bus.sram_wmode = cmd.wmode;
    assign bus.sram_addr  = cmd.addr;
    assign bus.sram_wmask = cmd.wmask;
    assign bus.sram_wdata = cmd.wdata;

endmodule
